// File: rtl/ram_fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller.
// Optional build macro used by ram_fifo_ctrl: RAM_FIFO_BYPASS_EN.
package ram_fifo_pkg;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    // Number of words held by a RAM with the given address width.
    function automatic int unsigned fifo_depth(input int unsigned address_bits);
        return 32'd1 << address_bits;
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for the single RAM port: read vs write.
// grant[0] = read, grant[1] = write; at most one bit set.
module ram_port_arbiter
    import ram_fifo_pkg::*;
(
    input  logic       read_req,
    input  logic       write_req,
    input  grant_t     last_grant,
    output logic [1:0] grant
);

    // Contention goes to the side that did not win last time.
    always_comb begin
        grant = 2'b00;
        priority case (1'b1)
            (read_req && write_req):
                grant = (last_grant == GRANT_WRITE) ? 2'b01 : 2'b10;
            read_req:
                grant = 2'b01;
            write_req:
                grant = 2'b10;
            default:
                grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external zero-delay single-port RAM.
// Define RAM_FIFO_BYPASS_EN to let pushes into an empty FIFO skip the RAM.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDRESS_BITS = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_BITS-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_BITS-1:0]    out_data,
    output logic [ADDRESS_BITS:0]   count,
    output logic                    ram_write,
    output logic [ADDRESS_BITS-1:0] ram_address,
    output logic [DATA_BITS-1:0]    ram_data_in,
    input  logic [DATA_BITS-1:0]    ram_data_out
);

    localparam int unsigned DEPTH = fifo_depth(ADDRESS_BITS);
    localparam logic [ADDRESS_BITS:0] FULL_LEVEL = (ADDRESS_BITS+1)'(DEPTH);

    logic [ADDRESS_BITS-1:0] wr_ptr;
    logic [ADDRESS_BITS-1:0] rd_ptr;
    logic [ADDRESS_BITS:0]   ram_count;
    grant_t                  last_grant;

    logic       ram_empty;
    logic       ram_full;
    logic       head_free;
    logic       read_req;
    logic       write_req;
    logic       bypass;
    logic [1:0] grant;
    logic       grant_read;
    logic       grant_write;

    assign ram_empty = (ram_count == '0);
    assign ram_full  = (ram_count == FULL_LEVEL);
    assign head_free = !out_valid || out_ready;

`ifdef RAM_FIFO_BYPASS_EN
    assign bypass = !reset && ram_empty && head_free && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign read_req  = !reset && !ram_empty && head_free;
    assign write_req = !reset && in_valid && !ram_full && !bypass;

    ram_port_arbiter u_arbiter (
        .read_req   (read_req),
        .write_req  (write_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign grant_read  = grant[0];
    assign grant_write = grant[1];

    // A pending prefetch that owns the next slot blocks the push side.
    assign in_ready = !reset && !ram_full
                    && !(read_req && last_grant == GRANT_WRITE);

    assign count = ram_count + (ADDRESS_BITS+1)'(out_valid);

    // Drive the RAM port; idle cycles park the address on the read pointer.
    always_comb begin
        ram_write   = 1'b0;
        ram_address = rd_ptr;
        ram_data_in = '0;
        if (grant_write) begin
            ram_write   = 1'b1;
            ram_address = wr_ptr;
            ram_data_in = in_data;
        end
    end

    // Pointers, RAM occupancy and arbitration history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            last_grant <= GRANT_READ;
        end else if (grant_write) begin
            wr_ptr     <= wr_ptr + ADDRESS_BITS'(1);
            ram_count  <= ram_count + (ADDRESS_BITS+1)'(1);
            last_grant <= GRANT_WRITE;
        end else if (grant_read) begin
            rd_ptr     <= rd_ptr + ADDRESS_BITS'(1);
            ram_count  <= ram_count - (ADDRESS_BITS+1)'(1);
            last_grant <= GRANT_READ;
        end
    end

    // Head register: refilled by prefetch or bypass, emptied by a bare pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (grant_read) begin
            out_valid <= 1'b1;
            out_data  <= ram_data_out;
        end else if (bypass) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a queue-based reference model.
// Build with RAM_FIFO_BYPASS_EN defined to exercise the bypass path.
module tb_ram_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int CAP = 4;

`ifdef RAM_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          ram_write;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    ram_fifo_ctrl #(.ADDRESS_BITS(AW), .DATA_BITS(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .ram_write    (ram_write),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Zero-delay RAM
    logic [DW-1:0] mem [CAP];
    always @(posedge clock) if (ram_write) mem[ram_address] <= ram_data_in;
    assign ram_data_out = mem[ram_address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RAM contents as a queue plus the head register.
    bit [7:0] mq[$];
    bit [7:0] sent[$];
    bit       mov;
    bit [7:0] mod;
    bit       mlg;
    int       mwp;
    int       mrp;
    bit       e_gw, e_gr, e_byp, e_push, e_pop;

    bit ph3;
    int ph3_n;
    bit prev_rw;
    bit ph4;
    int wr_cnt;

    // Per-cycle compare against the model's view of this cycle.
    always @(negedge clock) begin : cmp
        bit rr, wr, gw, gr, byp, ir;
        if (reset) begin
            e_gw <= 0; e_gr <= 0; e_byp <= 0; e_push <= 0; e_pop <= 0;
        end else begin
            rr  = mq.size() != 0 && (!mov || out_ready);
            byp = BYP && mq.size() == 0 && (!mov || out_ready) && in_valid;
            wr  = in_valid && mq.size() != CAP && !byp;
            gw  = wr && (!rr || !mlg);
            gr  = rr && !gw;
            ir  = mq.size() != CAP && !(rr && mlg);
            chk("in_ready", in_ready, ir);
            chk("ram_write", ram_write, gw);
            if (gw) begin
                chk("wr_addr", ram_address, mwp);
                chk("wr_data", ram_data_in, in_data);
            end else begin
                chk("rd_addr", ram_address, mrp);
                chk("idle_data", ram_data_in, 0);
            end
            if (ram_write) chk("wr_at_full", mq.size() == CAP, 0);
            chk("out_valid", out_valid, mov);
            if (mov) chk("out_data", out_data, mod);
            chk("count", count, mq.size() + mov);
            if (mov && out_ready) begin
                if (sent.size() == 0) chk("sb_underflow", 1, 0);
                else chk("sb_order", out_data, sent.pop_front());
            end
            if (ph3) begin
                if (ph3_n > 0) chk("p3_toggle", ram_write, !prev_rw);
                chk("p3_count_range", count >= 2 && count <= 3, 1);
                prev_rw <= ram_write;
                ph3_n <= ph3_n + 1;
            end
            if (ph4 && ram_write) wr_cnt <= wr_cnt + 1;
            e_gw <= gw; e_gr <= gr; e_byp <= byp;
            e_push <= in_valid && ir;
            e_pop <= mov && out_ready;
        end
    end

    // Model state update at each edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            sent.delete();
            mov <= 0; mod <= 0; mlg <= 0; mwp <= 0; mrp <= 0;
        end else begin
            if (e_push) sent.push_back(in_data);
            if (e_gw) begin
                mq.push_back(in_data);
                mwp <= (mwp + 1) % CAP;
                mlg <= 1;
            end
            if (e_gr) begin
                mod <= mq.pop_front();
                mov <= 1;
                mrp <= (mrp + 1) % CAP;
                mlg <= 0;
            end else if (e_byp) begin
                mod <= in_data;
                mov <= 1;
            end else if (e_pop) begin
                mov <= 0;
            end
        end
    end

    task automatic push(input bit [7:0] d);
        bit ok = 0;
        in_valid = 1; in_data = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock); ok = in_ready;
            @(posedge clock); #1;
        end
        in_valid = 0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic pop(output bit [7:0] d);
        bit ok = 0;
        d = 0;
        out_ready = 1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock); ok = out_valid; d = out_data;
            @(posedge clock); #1;
        end
        out_ready = 0;
        if (!ok) chk("pop_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (count == 0) break;
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        out_ready = 0;
        chk("drained", count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    bit [7:0] d;
    bit [7:0] got[$];
    int acc;
    int k;

    initial begin
        reset = 1; in_valid = 1; in_data = 8'h77; out_ready = 0;
        ph3 = 0; ph3_n = 0; prev_rw = 0; ph4 = 0; wr_cnt = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        @(posedge clock); #1;
        in_valid = 0; reset = 0;

        // 1: three pushes then ordered pops
        push(8'h11); push(8'h22); push(8'h33);
        @(negedge clock);
        chk("t1_count", count, 3);
        chk("t1_ov", out_valid, 1);
        chk("t1_head", out_data, 8'h11);
        @(posedge clock); #1;
        pop(d); chk("t1_pop0", d, 8'h11);
        pop(d); chk("t1_pop1", d, 8'h22);
        pop(d); chk("t1_pop2", d, 8'h33);

        // 2: overfill with out_ready low
        acc = 0; in_valid = 1; in_data = 8'hA0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (in_ready) acc++;
            @(posedge clock); #1;
            in_data = 8'(8'hA0 + acc);
        end
        chk("t2_accepted", acc, 5);
        @(negedge clock);
        chk("t2_count", count, 5);
        chk("t2_in_ready", in_ready, 0);
        out_ready = 1;
        @(posedge clock); #1;
        out_ready = 0;
        k = -1;
        for (int i = 0; i < 5 && k < 0; i++) begin
            @(negedge clock);
            if (in_ready) k = i;
            @(posedge clock); #1;
        end
        in_valid = 0;
        chk("t2_sixth_cycle", k, 0);
        for (int i = 0; i < 5; i++) begin
            pop(d); chk("t2_pop", d, 8'hA1 + i);
        end
        drain();

        // 3: continuous push+pop from a three-word backlog
        push(8'h31); push(8'h32); push(8'h33);
        in_valid = 1; out_ready = 1; in_data = 8'($urandom);
        ph3 = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            @(posedge clock); #1;
            in_data = 8'($urandom);
        end
        ph3 = 0; in_valid = 0; out_ready = 0;
        chk("t3_cycles", ph3_n, 20);
        drain();

        // 4: stream 0..9 with random consumer
        got.delete(); ph4 = 1;
        fork
            begin
                for (int w = 0; w < 10; w++) push(8'(w));
            end
            begin
                for (int c = 0; c < 400 && got.size() < 10; c++) begin
                    out_ready = 1'($urandom);
                    @(negedge clock);
                    if (out_valid && out_ready) got.push_back(out_data);
                    @(posedge clock); #1;
                end
                out_ready = 0;
            end
        join
        ph4 = 0;
        chk("t4_len", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk("t4_seq", got[i], i);
        if (!BYP) chk("t4_writes", wr_cnt, 10);
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_data = 8'($urandom);
            out_ready = (i < 150) ? (($urandom % 4) == 0) : 1'($urandom);
            @(posedge clock); #1;
        end
        in_valid = 0;
        drain();

        // 5: asynchronous reset mid-operation
        push(8'h51); push(8'h52); push(8'h53);
        @(negedge clock);
        chk("t5_count", count, 3);
        #2 reset = 1;
        #1;
        chk("t5_ov", out_valid, 0);
        chk("t5_count0", count, 0);
        chk("t5_in_ready", in_ready, 0);
        @(posedge clock); #1;
        reset = 0;
        push(8'hAA);
        pop(d); chk("t5_pop", d, 8'hAA);

`ifdef RAM_FIFO_BYPASS_EN
        // 6: bypass into empty FIFO
        in_valid = 1; in_data = 8'h5C;
        @(negedge clock);
        chk("t6_ram_write", ram_write, 0);
        @(posedge clock); #1;
        in_valid = 0;
        @(negedge clock);
        chk("t6_ov", out_valid, 1);
        chk("t6_data", out_data, 8'h5C);
        chk("t6_count", count, 1);
        @(posedge clock); #1;
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
